operand_collector: RTL and testbench
====================================

Name: operand_collector

Overview:
- Sits directly upstream of the q = ((a-b)*(3c+1) - 4d) >>> 1 arithmetic pipeline. That pipeline only issues a valid result when all four operand valids are high in the same cycle.
- This block gathers a, b, c, d arriving on independent valid strobes in any order and any cycle. It holds partial sets and issues each complete set as one aligned bundle, with all four output valids high for exactly one cycle.
- A partial set is discarded by a timeout. Duplicate operands are reported.

Parameters:
- DATA_WIDTH, 16, width of each signed operand.
- TIMEOUT_CYCLES, 64, cycles a partial set may stay in COLLECT before it is discarded; 0 disables the timeout; legal range 0..65535.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- srst_i  in  1  synchronous active-high reset.
- a_i, b_i, c_i, d_i  in  DATA_WIDTH each  signed operands.
- a_valid_i, b_valid_i, c_valid_i, d_valid_i  in  1 each  per-operand strobe; operand captured on the edge where its strobe is high.
- a_o, b_o, c_o, d_o  out  DATA_WIDTH each  registered aligned operands for the downstream pipeline.
- a_valid_o, b_valid_o, c_valid_o, d_valid_o  out  1 each  always identical; high for one cycle per issued set.
- overwrite_o  out  1  one-cycle pulse: an already-pending operand was replaced.
- timeout_o  out  1  one-cycle pulse: a partial set was discarded.
- busy_o  out  1  high while state is COLLECT.

Behaviour:
- Interface: one clock, clk_i. Reset is srst_i, synchronous and active-high.
- Reset values:
  - all *_o data outputs = 0;
  - all valid outputs, overwrite_o, timeout_o, busy_o = 0;
  - pending flags cleared; timeout counter = 0; state IDLE.
- Reset mid-collection discards the partial set silently; no timeout_o pulse.
- Storage: one holding register and one pending flag per operand.
- Capture rule: operand x with x_valid_i=1 loads hold_x. If pending_x was already 1 and the set does not complete this cycle, the new value replaces the old one and overwrite_o pulses on the next cycle.
- Completion: evaluated each cycle as complete = &(pending | valid_i) over the four operands.
  - When complete, each output loads valid_i ? x_i : hold_x; valid_i wins over held data, and that also counts as an overwrite.
  - On the same edge all valid outputs go high and all pending flags clear.
  - Latency: all four strobes in cycle N gives the valid outputs high in cycle N+1. Back-to-back complete sets every cycle must be sustained (throughput 1 set per cycle).
- Data outputs hold their last issued value when the valid outputs are low.
- FSM:
  - IDLE (no pending): any strobe that does not complete a set goes to COLLECT, with the counter cleared to 0. A completing strobe set issues and stays in IDLE.
  - COLLECT:
    - if complete: issue, go to IDLE;
    - else if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: clear all pending, drop any operands strobed this cycle, pulse timeout_o next cycle, go to IDLE;
    - else: counter+1, capture strobes, stay in COLLECT.
- Completion and timeout in the same cycle: completion wins, no timeout_o.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1. It never wraps, because it is cleared on every COLLECT entry.
- busy_o = (state == COLLECT), registered.
- Arithmetic: none. Operands pass through bit-exact, signed, no extension or truncation.

Test Plan:
- Aligned set: a=10, b=4, c=2, d=3 all strobed in cycle 5 -> cycle 6: all valid outputs high for 1 cycle with a_o=10, b_o=4, c_o=2, d_o=3. The downstream pipeline then yields q=15.
- Staggered set: a strobed in cycle 0, c in 2, d in 3, b=-7 in 7 -> busy_o high in cycles 1-7, valid outputs high in cycle 8 only, b_o=-7; no overwrite_o, no timeout_o.
- Overwrite: a=1 in cycle 0, a=9 in cycle 1, b/c/d in cycle 2 -> overwrite_o high in cycle 2, issue in cycle 3 with a_o=9. A second case: a pending, then a=5 together with b/c/d -> issue with a_o=5 and overwrite_o high in the issue cycle.
- Timeout (TIMEOUT_CYCLES=4): a in cycle 0 only -> timeout_o high in cycle 5, busy_o low from cycle 5. A later b/c/d alone does not issue.
- Completion beats timeout (TIMEOUT_CYCLES=4): a in cycle 0, then b/c/d in cycle 4 -> valid outputs high in cycle 5, timeout_o stays 0.
- Reset and throughput:
  - srst_i high in cycle 3 with a and b pending -> all outputs 0 in cycle 4. Then c/d alone do not issue.
  - Full sets strobed every cycle for 8 cycles -> 8 consecutive valid-output cycles, with data matching the input order.

Source files
------------

// File: rtl/operand_collector.sv
// Operand collector: gathers a/b/c/d arriving on independent strobes and issues
// each complete set as one aligned bundle; stale partial sets are discarded by timeout.
module operand_collector #(
   parameter int DATA_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                         clk_i,
   input  logic                         srst_i,
   input  logic signed [DATA_WIDTH-1:0] a_i,
   input  logic signed [DATA_WIDTH-1:0] b_i,
   input  logic signed [DATA_WIDTH-1:0] c_i,
   input  logic signed [DATA_WIDTH-1:0] d_i,
   input  logic                         a_valid_i,
   input  logic                         b_valid_i,
   input  logic                         c_valid_i,
   input  logic                         d_valid_i,
   output logic signed [DATA_WIDTH-1:0] a_o,
   output logic signed [DATA_WIDTH-1:0] b_o,
   output logic signed [DATA_WIDTH-1:0] c_o,
   output logic signed [DATA_WIDTH-1:0] d_o,
   output logic                         a_valid_o,
   output logic                         b_valid_o,
   output logic                         c_valid_o,
   output logic                         d_valid_o,
   output logic                         overwrite_o,
   output logic                         timeout_o,
   output logic                         busy_o
);
   localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_COLLECT = 1'b1} state_t;

   state_t                          r_state;
   state_t                          w_state_nxt;
   logic [CNT_W-1:0]                r_cnt;
   logic [CNT_W-1:0]                w_cnt_nxt;
   logic [3:0]                      r_pending;
   logic [3:0]                      w_pending_nxt;
   logic [3:0][DATA_WIDTH-1:0]      r_hold;
   logic [3:0][DATA_WIDTH-1:0]      w_data_in;
   logic [3:0][DATA_WIDTH-1:0]      w_issue_data;
   logic [3:0]                      w_valid_in;
   logic                            w_complete;
   logic                            w_issue;
   logic                            w_capture;
   logic                            w_timeout;
   logic                            w_overwrite;

   assign w_valid_in  = {d_valid_i, c_valid_i, b_valid_i, a_valid_i};
   assign w_data_in   = {d_i, c_i, b_i, a_i};
   assign w_complete  = &(r_pending | w_valid_in);
   // A strobe on a pending slot is an overwrite whether it is captured or wins the issue mux.
   assign w_overwrite = (w_capture | w_issue) & (|(r_pending & w_valid_in));

   // Next-state, counter and pending-flag logic
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_pending_nxt = r_pending;
      w_issue       = 1'b0;
      w_capture     = 1'b0;
      w_timeout     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_complete) begin
               w_issue       = 1'b1;
               w_pending_nxt = 4'b0000;
            end else if (|w_valid_in) begin
               w_capture     = 1'b1;
               w_pending_nxt = r_pending | w_valid_in;
               w_cnt_nxt     = '0;
               w_state_nxt   = ST_COLLECT;
            end else begin
               w_state_nxt   = ST_IDLE;
            end
         end
         ST_COLLECT: begin
            if (w_complete) begin
               w_issue       = 1'b1;
               w_pending_nxt = 4'b0000;
               w_state_nxt   = ST_IDLE;
            end else if (TIMEOUT_EN && (r_cnt == CNT_LAST)) begin
               w_timeout     = 1'b1;
               w_pending_nxt = 4'b0000;
               w_state_nxt   = ST_IDLE;
            end else begin
               w_capture     = 1'b1;
               w_pending_nxt = r_pending | w_valid_in;
               if (TIMEOUT_EN) begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end else begin
                  w_cnt_nxt = r_cnt;
               end
            end
         end
         default: begin
            w_pending_nxt = 4'b0000;
            w_state_nxt   = ST_IDLE;
         end
      endcase
   end

   // Issue mux: a fresh strobe takes priority over the held value
   always_comb begin
      w_issue_data = r_hold;
      for (int i = 0; i < 4; i++) begin
         if (w_valid_in[i]) begin
            w_issue_data[i] = w_data_in[i];
         end else begin
            w_issue_data[i] = r_hold[i];
         end
      end
   end

   // State, holding registers and registered outputs
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_pending   <= 4'b0000;
         r_hold      <= '0;
         a_o         <= '0;
         b_o         <= '0;
         c_o         <= '0;
         d_o         <= '0;
         a_valid_o   <= 1'b0;
         b_valid_o   <= 1'b0;
         c_valid_o   <= 1'b0;
         d_valid_o   <= 1'b0;
         overwrite_o <= 1'b0;
         timeout_o   <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_pending <= w_pending_nxt;
         for (int i = 0; i < 4; i++) begin
            if (w_capture && w_valid_in[i]) begin
               r_hold[i] <= w_data_in[i];
            end
         end
         if (w_issue) begin
            a_o <= w_issue_data[0];
            b_o <= w_issue_data[1];
            c_o <= w_issue_data[2];
            d_o <= w_issue_data[3];
         end
         a_valid_o   <= w_issue;
         b_valid_o   <= w_issue;
         c_valid_o   <= w_issue;
         d_valid_o   <= w_issue;
         overwrite_o <= w_overwrite;
         timeout_o   <= w_timeout;
         busy_o      <= (w_state_nxt == ST_COLLECT);
      end
   end
endmodule

// File: tb/tb_operand_collector.sv
// Directed bench for operand_collector: one instance with the default timeout and
// one with TIMEOUT_CYCLES=4, both driven by the same stimulus.
module tb_operand_collector;
   logic        clk;
   logic        srst;
   logic [15:0] a, b, c, d;
   logic        av, bv, cv, dv;

   logic [15:0] ya, yb, yc, yd;
   logic        yav, ybv, ycv, ydv, yov, yto, ybusy;
   logic [15:0] za, zb, zc, zd;
   logic        zav, zbv, zcv, zdv, zov, zto, zbusy;

   int n_checks = 0;
   int n_errors = 0;

   operand_collector u64 (
      .clk_i(clk), .srst_i(srst),
      .a_i(a), .b_i(b), .c_i(c), .d_i(d),
      .a_valid_i(av), .b_valid_i(bv), .c_valid_i(cv), .d_valid_i(dv),
      .a_o(ya), .b_o(yb), .c_o(yc), .d_o(yd),
      .a_valid_o(yav), .b_valid_o(ybv), .c_valid_o(ycv), .d_valid_o(ydv),
      .overwrite_o(yov), .timeout_o(yto), .busy_o(ybusy)
   );

   operand_collector #(.DATA_WIDTH(16), .TIMEOUT_CYCLES(4)) u4 (
      .clk_i(clk), .srst_i(srst),
      .a_i(a), .b_i(b), .c_i(c), .d_i(d),
      .a_valid_i(av), .b_valid_i(bv), .c_valid_i(cv), .d_valid_i(dv),
      .a_o(za), .b_o(zb), .c_o(zc), .d_o(zd),
      .a_valid_o(zav), .b_valid_o(zbv), .c_valid_o(zcv), .d_valid_o(zdv),
      .overwrite_o(zov), .timeout_o(zto), .busy_o(zbusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      av = 1'b0; bv = 1'b0; cv = 1'b0; dv = 1'b0;
   endtask

   task automatic do_reset();
      clr();
      srst = 1'b1;
      tick();
      srst = 1'b0;
   endtask

   initial begin
      a = 16'd0; b = 16'd0; c = 16'd0; d = 16'd0;
      clr();
      srst = 1'b1;
      tick();
      tick();
      srst = 1'b0;

      // reset state
      chk("rst_valid",   {12'd0, yav, ybv, ycv, ydv}, 16'd0);
      chk("rst_flags",   {13'd0, yov, yto, ybusy},    16'd0);
      chk("rst_a_o",     ya, 16'd0);
      chk("rst_d_o",     yd, 16'd0);

      // aligned set
      a = 16'd10; b = 16'd4; c = 16'd2; d = 16'd3;
      av = 1'b1; bv = 1'b1; cv = 1'b1; dv = 1'b1;
      tick();
      clr();
      chk("al_valid", {12'd0, yav, ybv, ycv, ydv}, 16'hF);
      chk("al_a", ya, 16'd10);
      chk("al_b", yb, 16'd4);
      chk("al_c", yc, 16'd2);
      chk("al_d", yd, 16'd3);
      chk("al_busy", {15'd0, ybusy}, 16'd0);
      tick();
      chk("al_valid_off", {12'd0, yav, ybv, ycv, ydv}, 16'd0);
      chk("al_a_hold", ya, 16'd10);

      // staggered: a@0, c@2, d@3, b=-7@7
      for (int cyc = 0; cyc < 8; cyc++) begin
         clr();
         if (cyc == 0) begin a = 16'd100; av = 1'b1; end
         if (cyc == 2) begin c = 16'd20;  cv = 1'b1; end
         if (cyc == 3) begin d = 16'd30;  dv = 1'b1; end
         if (cyc == 7) begin b = 16'hFFF9; bv = 1'b1; end
         tick();
         clr();
         if (cyc < 7) begin
            chk("st_busy",  {15'd0, ybusy}, 16'd1);
            chk("st_valid", {15'd0, yav},   16'd0);
         end else begin
            chk("st_busy_end", {15'd0, ybusy}, 16'd0);
            chk("st_valid", {12'd0, yav, ybv, ycv, ydv}, 16'hF);
         end
         chk("st_ovr", {15'd0, yov}, 16'd0);
         chk("st_to",  {15'd0, yto}, 16'd0);
      end
      chk("st_a", ya, 16'd100);
      chk("st_b", yb, 16'hFFF9);
      chk("st_c", yc, 16'd20);
      chk("st_d", yd, 16'd30);
      tick();
      chk("st_valid_off", {15'd0, yav}, 16'd0);

      // overwrite while collecting
      a = 16'd1; av = 1'b1;
      tick(); clr();
      chk("ow1_pulse0", {15'd0, yov}, 16'd0);
      a = 16'd9; av = 1'b1;
      tick(); clr();
      chk("ow1_pulse", {15'd0, yov}, 16'd1);
      chk("ow1_valid0", {15'd0, yav}, 16'd0);
      b = 16'd2; c = 16'd3; d = 16'd4; bv = 1'b1; cv = 1'b1; dv = 1'b1;
      tick(); clr();
      chk("ow1_valid", {15'd0, yav}, 16'd1);
      chk("ow1_a", ya, 16'd9);
      chk("ow1_pulse_off", {15'd0, yov}, 16'd0);

      // overwrite in the completing cycle
      a = 16'd7; av = 1'b1;
      tick(); clr();
      a = 16'd5; b = 16'd6; c = 16'd8; d = 16'd11;
      av = 1'b1; bv = 1'b1; cv = 1'b1; dv = 1'b1;
      tick(); clr();
      chk("ow2_valid", {15'd0, yav}, 16'd1);
      chk("ow2_a", ya, 16'd5);
      chk("ow2_d", yd, 16'd11);
      chk("ow2_pulse", {15'd0, yov}, 16'd1);

      // timeout with TIMEOUT_CYCLES=4
      do_reset();
      a = 16'd42; av = 1'b1;
      tick(); clr();
      chk("to_busy1", {15'd0, zbusy}, 16'd1);
      tick(); tick(); tick();
      chk("to_c4_to",   {15'd0, zto},   16'd0);
      chk("to_c4_busy", {15'd0, zbusy}, 16'd1);
      tick();
      chk("to_c5_to",   {15'd0, zto},   16'd1);
      chk("to_c5_busy", {15'd0, zbusy}, 16'd0);
      tick();
      chk("to_c6_to", {15'd0, zto}, 16'd0);
      b = 16'd1; c = 16'd2; d = 16'd3; bv = 1'b1; cv = 1'b1; dv = 1'b1;
      tick(); clr();
      chk("to_no_issue", {15'd0, zav}, 16'd0);
      chk("to_recollect", {15'd0, zbusy}, 16'd1);

      // completion beats timeout
      do_reset();
      a = 16'd11; av = 1'b1;
      tick(); clr();
      tick(); tick(); tick();
      b = 16'd12; c = 16'd13; d = 16'd14; bv = 1'b1; cv = 1'b1; dv = 1'b1;
      tick(); clr();
      chk("cb_valid", {12'd0, zav, zbv, zcv, zdv}, 16'hF);
      chk("cb_to",    {15'd0, zto}, 16'd0);
      chk("cb_a",     za, 16'd11);
      tick();
      chk("cb_to_after", {15'd0, zto}, 16'd0);

      // reset mid-collection
      do_reset();
      a = 16'd77; b = 16'd88; av = 1'b1; bv = 1'b1;
      tick(); clr();
      tick(); tick();
      srst = 1'b1;
      tick();
      srst = 1'b0;
      chk("mr_valid", {12'd0, yav, ybv, ycv, ydv}, 16'd0);
      chk("mr_flags", {13'd0, yov, yto, ybusy}, 16'd0);
      chk("mr_a", ya, 16'd0);
      chk("mr_b", yb, 16'd0);
      c = 16'd5; d = 16'd6; cv = 1'b1; dv = 1'b1;
      tick(); clr();
      chk("mr_no_issue", {15'd0, yav}, 16'd0);
      tick();
      chk("mr_no_to", {15'd0, yto}, 16'd0);

      // throughput: one full set per cycle for 8 cycles
      do_reset();
      for (int i = 0; i < 8; i++) begin
         a = 16'(100 + i); b = 16'(200 + i); c = 16'(300 + i); d = 16'(400 + i);
         av = 1'b1; bv = 1'b1; cv = 1'b1; dv = 1'b1;
         tick();
         chk("tp_valid", {12'd0, yav, ybv, ycv, ydv}, 16'hF);
         chk("tp_a", ya, 16'(100 + i));
         chk("tp_d", yd, 16'(400 + i));
         chk("tp_busy", {15'd0, ybusy}, 16'd0);
      end
      clr();
      tick();
      chk("tp_valid_off", {15'd0, yav}, 16'd0);
      chk("tp_a_hold", ya, 16'd107);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
